// File: rtl/display_scan_mux.sv
// display_scan_mux: self-sequencing N-channel scan multiplexer for a
// multiplexed display. Each enabled channel gets a slot of DIV clocks. A slot
// opens with BLANK clocks of all-zero select and then shows the channel. The
// channel value and index are captured once at slot start, so they stay
// stable for the whole slot.
module display_scan_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DIV      = 1000,
  parameter int BLANK    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [CHANNELS-1:0]           chan_mask,
  input  logic [CHANNELS*WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]              data_out,
  output logic [$clog2(CHANNELS)-1:0]   sel_idx,
  output logic [CHANNELS-1:0]           sel_onehot,
  output logic                          frame_start
);

  localparam int IDXW = $clog2(CHANNELS);
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CHANNELS-1:0] SEL_ONE = CHANNELS'(1);

  // Scan states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [CHANNELS-1:0] onehot_q, onehot_d;
  logic                fs_q, fs_d;

  // Per-channel view of the flat input bus
  logic [WIDTH-1:0] chan_data [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_data[gi] = data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scanning is only meaningful with at least one channel enabled
  logic run_ok;
  assign run_ok = enable & (|chan_mask);

  // Lowest enabled channel: start of every frame and the wrap target
  logic [IDXW-1:0] low_idx;
  always_comb begin
    low_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (chan_mask[i]) begin
        low_idx = IDXW'(i);
      end
    end
  end

  // Nearest enabled channel strictly above the current one, if any
  logic [IDXW-1:0] above_idx;
  logic            above_found;
  always_comb begin
    above_idx   = '0;
    above_found = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (chan_mask[i] && (i > int'(idx_q))) begin
        above_idx   = IDXW'(i);
        above_found = 1'b1;
      end
    end
  end

  // Next slot's channel; taking the wrap target means a new frame begins,
  // which also covers a single enabled channel wrapping onto itself.
  logic [IDXW-1:0] next_idx;
  logic            next_wraps;
  assign next_idx   = above_found ? above_idx : low_idx;
  assign next_wraps = ~above_found;

  // Next-state logic; defaults describe IDLE so any stop condition clears all
  always_comb begin
    state_d  = S_IDLE;
    cnt_d    = '0;
    idx_d    = '0;
    data_d   = '0;
    onehot_d = '0;
    fs_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_ok) begin
          state_d = S_BLANK;
          idx_d   = low_idx;
          data_d  = chan_data[low_idx];
          fs_d    = 1'b1;
        end
      end
      S_BLANK: begin
        if (run_ok) begin
          idx_d  = idx_q;
          data_d = data_q;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) begin
            state_d  = S_SHOW;
            onehot_d = SEL_ONE << idx_q;
          end else begin
            state_d = S_BLANK;
          end
        end
      end
      S_SHOW: begin
        if (run_ok) begin
          if (cnt_q == CNT_LAST) begin
            // Slot boundary: pick the next channel and snapshot its data
            state_d = S_BLANK;
            idx_d   = next_idx;
            data_d  = chan_data[next_idx];
            fs_d    = next_wraps;
          end else begin
            state_d  = S_SHOW;
            cnt_d    = cnt_q + 1'b1;
            idx_d    = idx_q;
            data_d   = data_q;
            onehot_d = SEL_ONE << idx_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      onehot_q <= '0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      onehot_q <= onehot_d;
      fs_q     <= fs_d;
    end
  end

  assign data_out    = data_q;
  assign sel_idx     = idx_q;
  assign sel_onehot  = onehot_q;
  assign frame_start = fs_q;

endmodule
